jpeg_input_block: RTL and testbench
===================================

# jpeg_input_block

Front-end of the encoder path: accepts RGB pixels in 8x8 block order, converts them to level-shifted YCbCr, and emits 64-entry sample blocks tagged with the same `{type, block_y, block_x}` id word and 0–63 index that the decoder output stage consumes. It sits between the pixel source and the forward DCT. Y samples stream through with one cycle of latency; Cb and Cr samples are buffered per block and replayed after the Y block.

## Interface
Parameters: none.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `img_start_i` in 1: synchronous flush / start of image.
- `img_end_i` in 1: one-cycle pulse; image complete after the current block.
- `img_mode_i` in 2: 0 = monochrome, 1 = YCbCr 4:4:4, 2/3 = unsupported.
- `inport_valid_i` in 1: pixel valid.
- `inport_pixel_x_i`, `inport_pixel_y_i` in 16: pixel coordinates.
- `inport_pixel_r_i`, `inport_pixel_g_i`, `inport_pixel_b_i` in 8: colour components.
- `inport_accept_o` out 1: pixel accepted.
- `outport_valid_o` out 1: sample valid.
- `outport_data_o` out 32: signed sample.
- `outport_idx_o` out 6: index within the block.
- `outport_id_o` out 32: `[31:30]` type (0 = Y, 1 = Cb, 2 = Cr, 3 = EOF), `[29:16]` = y>>3, `[15:0]` = x>>3.
- `outport_accept_i` in 1: sink accepts the sample.
- `idle_o` out 1: no image in progress.

## Operation
- **Pixel order:** pixels must arrive in block order, raster within each block. The internal counter `cnt_q` (0..63) supplies `idx`; coordinates are used only at `cnt_q==0`, where x and y are latched into the block id. Coordinates are not checked.
- **Conversion:** all arithmetic is signed 32-bit with arithmetic right shift (floor).
  - Y = ((1225R + 2404G + 467B) >>> 12) − 128
  - Cb = (−691R − 1357G + 2048B) >>> 12
  - Cr = (2048R − 1715G − 333B) >>> 12
  - Cb and Cr are stored as 8-bit signed values; the range is exactly −128..127.
- **States:**
  - IDLE: reset state, or after EOF.
  - Y: stream Y samples. At the accept of the `cnt_q==63` pixel, go to CB if mode 1; if mode 0, stay in Y.
  - CB: emit Cb buffer idx 0..63 with type 1, then go to CR.
  - CR: emit Cr buffer idx 0..63 with type 2, then go to Y.
  - EOF: emit 64 words with data 0, idx 0..63, id `{2'b11, 30'b0}`, then go to IDLE.
- **Buffers:** two 64x8 buffers (Cb, Cr). Both are written in the cycle a pixel is accepted, at address `cnt_q`.
- **End of image:**
  - `img_end_i` sets `end_pend_q`.
  - In state Y with `cnt_q==0` and `end_pend_q` set, go to EOF and clear `end_pend_q`.
  - `img_end_i` arriving mid-block takes effect after that block's Cr replay (or after the Y block in mode 0).
- **Unsupported modes (2/3):** `inport_accept_o`=1 and pixels are dropped. No output is produced.
- **`img_start_i`:** state goes to Y; `cnt_q`, the replay counter and `end_pend_q` are cleared; `outport_valid_o` is cleared; `idle_o` goes to 0. If asserted in the same cycle as `img_end_i`, start wins and the end is discarded.
- **`idle_o`:** 1 at reset. It goes to 0 on `img_start_i` and back to 1 after the 64th EOF word is accepted.

## Timing
- Reset values: `outport_valid_o`=0, `outport_data_o`=0, `outport_idx_o`=0, `outport_id_o`=0, `idle_o`=1, `inport_accept_o`=0, state IDLE.
- Output register advances when `output_space = !outport_valid_o || outport_accept_i`.
- `inport_accept_o = output_space && state==Y`. It is combinational from `outport_accept_i`. In modes 2/3 it is 1 (see Operation).
- Y latency: a pixel accepted in cycle N appears on the output in cycle N+1.
- Throughput is one pixel per cycle. Per block: mode 0 takes 64 cycles, mode 1 takes 192 cycles.
- Replay: each output word is presented one cycle after the buffer read, so there is no gap when `outport_accept_i` is held high. The CB→CR and CR→Y transitions are bubble-free.
- Back-pressure: while `outport_valid_o` is high and `outport_accept_i` is low, all output fields hold stable.
- Asynchronous reset mid-block: buffer contents are don't-care and all state returns to its reset value.

## Configuration
- `JPEG_INPUT_YCBCR_EN`
  - Defined: full behaviour as above.
  - Undefined: Cb/Cr multipliers, buffers and the CB/CR states are removed, and mode 1 behaves as mode 0 (Y blocks only).

## Test plan
- Mode 0, 64 pixels (0,0,0) at x=16, y=8: 64 words of data −128, idx 0..63, id 0x0001_0002; then `img_end_i` produces 64 EOF words and `idle_o`=1.
- Mode 1, pixel (255,0,0) everywhere: Y words = −52, then Cb = −44 (id[31:30]=1), then Cr = 127 (id[31:30]=2), 192 words total.
- Mode 1, pixel (255,255,255): Y = 127, Cb = 0, Cr = 0.
- Random `outport_accept_i` stalls of 0–3 cycles: data, idx and id remain in order and stable during stalls; no sample is lost or duplicated.
- `img_end_i` at pixel 30 of a mode 1 block: the block completes with Y, Cb and Cr, then EOF follows.
- `img_start_i` mid-Cr replay: `outport_valid_o`=0 next cycle, and the next pixel is emitted with idx 0.

Source files
------------

// File: rtl/jpeg_input_block_if.sv
// Handshake buses around jpeg_input_block: RGB pixel input and YCbCr sample output.
interface jpeg_pixel_if;
    logic        valid;
    logic [15:0] pixel_x;
    logic [15:0] pixel_y;
    logic [7:0]  pixel_r;
    logic [7:0]  pixel_g;
    logic [7:0]  pixel_b;
    logic        accept;

    modport master (
        output valid, pixel_x, pixel_y, pixel_r, pixel_g, pixel_b,
        input  accept
    );
    modport slave (
        input  valid, pixel_x, pixel_y, pixel_r, pixel_g, pixel_b,
        output accept
    );
endinterface

interface jpeg_sample_if;
    logic        valid;
    logic [31:0] data;
    logic [5:0]  idx;
    logic [31:0] id;
    logic        accept;

    modport master (
        output valid, data, idx, id,
        input  accept
    );
    modport slave (
        input  valid, data, idx, id,
        output accept
    );
endinterface

// File: rtl/jpeg_input_block.sv
// RGB 8x8-block pixel stream to level-shifted Y/Cb/Cr sample blocks for the forward DCT.
// Define JPEG_INPUT_YCBCR_EN to build the Cb/Cr buffers and replay states; otherwise Y only.
module jpeg_input_block (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          img_start_i,
    input  logic          img_end_i,
    input  logic [1:0]    img_mode_i,
    output logic          idle_o,
    jpeg_pixel_if.slave   inport,
    jpeg_sample_if.master outport
);
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned REP_W     = 7;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned FRAC_W    = 12;
    localparam int unsigned BLK_LAST  = 63;
    localparam int unsigned EOF_WORDS = 64;
    localparam int unsigned BY_W      = 14;
    localparam int unsigned BX_W      = 16;

    localparam logic [1:0] TYPE_Y   = 2'd0;
    localparam logic [1:0] TYPE_EOF = 2'd3;
`ifdef JPEG_INPUT_YCBCR_EN
    localparam logic [1:0] TYPE_CB  = 2'd1;
    localparam logic [1:0] TYPE_CR  = 2'd2;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_Y    = 3'd1,
`ifdef JPEG_INPUT_YCBCR_EN
        ST_CB   = 3'd2,
        ST_CR   = 3'd3,
`endif
        ST_EOF  = 3'd4
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    cnt_q;
    logic [REP_W-1:0]    rep_q;
    logic                end_pend_q;
    logic [BY_W-1:0]     blk_y_q;
    logic [BX_W-1:0]     blk_x_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [IDX_W-1:0]    out_idx_q;
    logic [DATA_W-1:0]   out_id_q;
    logic                idle_q;

    function automatic logic [DATA_W-1:0] make_id(input logic [1:0] kind,
                                                  input logic [BY_W-1:0] by,
                                                  input logic [BX_W-1:0] bx);
        return {kind, by, bx};
    endfunction

    // Handshake qualifiers; unsupported modes swallow pixels without producing output
    logic mode_ok_c;
    logic out_space_c;
    logic eof_go_c;
    logic pix_fire_c;

    assign mode_ok_c   = (img_mode_i == 2'd0) || (img_mode_i == 2'd1);
    assign out_space_c = !out_valid_q || outport.accept;
    assign eof_go_c    = (state_q == ST_Y) && (cnt_q == '0) && end_pend_q;
    assign inport.accept = mode_ok_c ? (out_space_c && (state_q == ST_Y) && !eof_go_c) : 1'b1;
    assign pix_fire_c  = inport.valid && inport.accept && mode_ok_c;

    // Block id comes from the first pixel of the block; later coordinates are ignored
    logic [BY_W-1:0] blk_y_c;
    logic [BX_W-1:0] blk_x_c;

    assign blk_y_c = (cnt_q == '0) ? BY_W'(inport.pixel_y >> 3) : blk_y_q;
    assign blk_x_c = (cnt_q == '0) ? BX_W'(inport.pixel_x >> 3) : blk_x_q;

    logic signed [DATA_W-1:0] r_s;
    logic signed [DATA_W-1:0] g_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [DATA_W-1:0] y_sum_c;
    logic signed [DATA_W-1:0] y_c;

    assign r_s     = $signed(DATA_W'(inport.pixel_r));
    assign g_s     = $signed(DATA_W'(inport.pixel_g));
    assign b_s     = $signed(DATA_W'(inport.pixel_b));
    assign y_sum_c = 32'sd1225 * r_s + 32'sd2404 * g_s + 32'sd467 * b_s;
    assign y_c     = (y_sum_c >>> FRAC_W) - 32'sd128;

`ifdef JPEG_INPUT_YCBCR_EN
    logic signed [DATA_W-1:0] cb_sum_c;
    logic signed [DATA_W-1:0] cr_sum_c;
    logic [7:0]               cb8_c;
    logic [7:0]               cr8_c;
    logic [7:0]               cb_buf_q [64];
    logic [7:0]               cr_buf_q [64];
    logic [7:0]               cb_rd_c;
    logic [7:0]               cr_rd_c;

    // Chroma always lands in -128..127, so 8 bits hold it exactly
    assign cb_sum_c = 32'sd2048 * b_s - 32'sd691 * r_s - 32'sd1357 * g_s;
    assign cr_sum_c = 32'sd2048 * r_s - 32'sd1715 * g_s - 32'sd333 * b_s;
    assign cb8_c    = 8'(cb_sum_c >>> FRAC_W);
    assign cr8_c    = 8'(cr_sum_c >>> FRAC_W);
    assign cb_rd_c  = cb_buf_q[rep_q[IDX_W-1:0]];
    assign cr_rd_c  = cr_buf_q[rep_q[IDX_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (pix_fire_c) begin
            cb_buf_q[cnt_q] <= cb8_c;
            cr_buf_q[cnt_q] <= cr8_c;
        end
    end

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        return {{(DATA_W-8){v[7]}}, v};
    endfunction
`endif

    // Control FSM and registered output stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rep_q       <= '0;
            end_pend_q  <= 1'b0;
            blk_y_q     <= '0;
            blk_x_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_id_q    <= '0;
            idle_q      <= 1'b1;
        end else if (img_start_i) begin
            state_q     <= ST_Y;
            cnt_q       <= '0;
            rep_q       <= '0;
            end_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            if (img_end_i) begin
                end_pend_q <= 1'b1;
            end
            if (out_space_c) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_Y: begin
                    if (eof_go_c) begin
                        state_q    <= ST_EOF;
                        end_pend_q <= 1'b0;
                        rep_q      <= '0;
                    end else if (pix_fire_c) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= y_c;
                        out_idx_q   <= cnt_q;
                        out_id_q    <= make_id(TYPE_Y, blk_y_c, blk_x_c);
                        blk_y_q     <= blk_y_c;
                        blk_x_q     <= blk_x_c;
                        cnt_q       <= cnt_q + IDX_W'(1);
`ifdef JPEG_INPUT_YCBCR_EN
                        if ((cnt_q == IDX_W'(BLK_LAST)) && (img_mode_i == 2'd1)) begin
                            state_q <= ST_CB;
                            rep_q   <= '0;
                        end
`endif
                    end
                end
`ifdef JPEG_INPUT_YCBCR_EN
                ST_CB: begin
                    if (out_space_c) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= sext8(cb_rd_c);
                        out_idx_q   <= rep_q[IDX_W-1:0];
                        out_id_q    <= make_id(TYPE_CB, blk_y_q, blk_x_q);
                        if (rep_q == REP_W'(BLK_LAST)) begin
                            rep_q   <= '0;
                            state_q <= ST_CR;
                        end else begin
                            rep_q <= rep_q + REP_W'(1);
                        end
                    end
                end
                ST_CR: begin
                    if (out_space_c) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= sext8(cr_rd_c);
                        out_idx_q   <= rep_q[IDX_W-1:0];
                        out_id_q    <= make_id(TYPE_CR, blk_y_q, blk_x_q);
                        if (rep_q == REP_W'(BLK_LAST)) begin
                            rep_q   <= '0;
                            state_q <= ST_Y;
                        end else begin
                            rep_q <= rep_q + REP_W'(1);
                        end
                    end
                end
`endif
                ST_EOF: begin
                    // Stay until the last EOF word has been taken, then report idle
                    if (out_space_c) begin
                        if (rep_q == REP_W'(EOF_WORDS)) begin
                            rep_q   <= '0;
                            state_q <= ST_IDLE;
                            idle_q  <= 1'b1;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= '0;
                            out_idx_q   <= rep_q[IDX_W-1:0];
                            out_id_q    <= {TYPE_EOF, 30'd0};
                            rep_q       <= rep_q + REP_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign outport.valid = out_valid_q;
    assign outport.data  = out_data_q;
    assign outport.idx   = out_idx_q;
    assign outport.id    = out_id_q;
    assign idle_o        = idle_q;

endmodule

// File: tb/tb_jpeg_input_block.sv
// Randomised bench for jpeg_input_block with a queue-based reference model of the sample stream.
module tb_jpeg_input_block;
`ifdef JPEG_INPUT_YCBCR_EN
    localparam bit YC = 1'b1;
`else
    localparam bit YC = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       img_start_i = 1'b0;
    logic       img_end_i = 1'b0;
    logic [1:0] img_mode_i = 2'd0;
    logic       idle_o;

    jpeg_pixel_if  pix();
    jpeg_sample_if smp();

    jpeg_input_block dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .img_start_i (img_start_i),
        .img_end_i   (img_end_i),
        .img_mode_i  (img_mode_i),
        .idle_o      (idle_o),
        .inport      (pix),
        .outport     (smp)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  idx;
        logic [31:0] id;
    } word_t;

    word_t expq[$];

    int          pr[64];
    int          pg[64];
    int          pb[64];
    logic [15:0] blk_x;
    logic [15:0] blk_y;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic: true floor division rather than shifts
    function automatic int floor_div(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction
    function automatic int y_of(input int r, input int g, input int b);
        return floor_div(1225 * r + 2404 * g + 467 * b, 4096) - 128;
    endfunction
    function automatic int cb_of(input int r, input int g, input int b);
        return floor_div(-691 * r - 1357 * g + 2048 * b, 4096);
    endfunction
    function automatic int cr_of(input int r, input int g, input int b);
        return floor_div(2048 * r - 1715 * g - 333 * b, 4096);
    endfunction

    task automatic push_block(input int mode);
        word_t w;
        logic [13:0] by;
        logic [15:0] bx;
        by = 14'(blk_y >> 3);
        bx = blk_x >> 3;
        for (int i = 0; i < 64; i++) begin
            w.data = 32'(y_of(pr[i], pg[i], pb[i]));
            w.idx  = 6'(i);
            w.id   = {2'd0, by, bx};
            expq.push_back(w);
        end
        if (YC && mode == 1) begin
            for (int i = 0; i < 64; i++) begin
                w.data = 32'(cb_of(pr[i], pg[i], pb[i]));
                w.idx  = 6'(i);
                w.id   = {2'd1, by, bx};
                expq.push_back(w);
            end
            for (int i = 0; i < 64; i++) begin
                w.data = 32'(cr_of(pr[i], pg[i], pb[i]));
                w.idx  = 6'(i);
                w.id   = {2'd2, by, bx};
                expq.push_back(w);
            end
        end
    endtask

    task automatic push_eof();
        word_t w;
        for (int i = 0; i < 64; i++) begin
            w.data = 32'd0;
            w.idx  = 6'(i);
            w.id   = 32'hC000_0000;
            expq.push_back(w);
        end
    endtask

    // Output stall generator: random 0-3 cycle gaps when enabled
    bit stall_en   = 1'b0;
    int stall_left = 0;
    always @(posedge clk_i) begin
        #1;
        if (stall_left > 0) begin
            smp.accept = 1'b0;
            stall_left--;
        end else begin
            smp.accept = 1'b1;
            if (stall_en) stall_left = $urandom_range(0, 3);
        end
    end

    // Compare process: every transferred word against the model, every stall for stability
    bit    flushing = 1'b0;
    bit    held = 1'b0;
    word_t hold_w;
    always @(negedge clk_i) begin
        word_t e;
        if (rst_i || flushing) begin
            held = 1'b0;
        end else begin
            if (held) begin
                total++;
                if (!(smp.valid === 1'b1 && smp.data === hold_w.data &&
                      smp.idx === hold_w.idx && smp.id === hold_w.id)) begin
                    bad++;
                    $display("FAIL hold: got v=%0b data=%0h idx=%0d id=%0h expected data=%0h idx=%0d id=%0h",
                             smp.valid, smp.data, smp.idx, smp.id, hold_w.data, hold_w.idx, hold_w.id);
                end
            end
            held = 1'b0;
            if (smp.valid === 1'b1) begin
                if (smp.accept !== 1'b1) begin
                    held = 1'b1;
                    hold_w.data = smp.data;
                    hold_w.idx  = smp.idx;
                    hold_w.id   = smp.id;
                end else begin
                    total++;
                    if (expq.size() == 0) begin
                        bad++;
                        $display("FAIL extra_word: got data=%0h idx=%0d id=%0h expected none",
                                 smp.data, smp.idx, smp.id);
                    end else begin
                        e = expq.pop_front();
                        if (smp.data !== e.data || smp.idx !== e.idx || smp.id !== e.id) begin
                            bad++;
                            $display("FAIL stream: got data=%0h idx=%0d id=%0h expected data=%0h idx=%0d id=%0h",
                                     smp.data, smp.idx, smp.id, e.data, e.idx, e.id);
                        end
                    end
                end
            end
        end
    end

    task automatic send_pixel(input logic [15:0] x, input logic [15:0] y,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bit ok = 1'b0;
        pix.valid   = 1'b1;
        pix.pixel_x = x;
        pix.pixel_y = y;
        pix.pixel_r = r;
        pix.pixel_g = g;
        pix.pixel_b = b;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk_i);
            if (pix.accept === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL pixel_accept: got no accept expected accept within 2000 cycles");
        end
        @(posedge clk_i);
        #1;
        pix.valid = 1'b0;
    endtask

    task automatic send_block(input int n, input int end_at, input bit chk,
                              input logic [31:0] exp_data, input logic [31:0] exp_id);
        for (int i = 0; i < n; i++) begin
            if (i == end_at) pulse_end();
            send_pixel(blk_x + 16'(i % 8), blk_y + 16'(i / 8), 8'(pr[i]), 8'(pg[i]), 8'(pb[i]));
            if (chk && i == 0) begin
                check("first_valid", 32'(smp.valid), 32'd1);
                check("first_data", smp.data, exp_data);
                check("first_idx", 32'(smp.idx), 32'd0);
                check("first_id", smp.id, exp_id);
            end
        end
    endtask

    task automatic start_img(input logic [1:0] mode);
        img_mode_i  = mode;
        img_start_i = 1'b1;
        @(posedge clk_i);
        #1;
        img_start_i = 1'b0;
        check("idle_after_start", 32'(idle_o), 32'd0);
    endtask

    task automatic pulse_end();
        img_end_i = 1'b1;
        @(posedge clk_i);
        #1;
        img_end_i = 1'b0;
    endtask

    task automatic wait_idle_drained();
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk_i);
            if (idle_o === 1'b1) break;
        end
        check("idle_after_eof", 32'(idle_o), 32'd1);
        check("queue_drained", 32'(expq.size()), 32'd0);
    endtask

    task automatic fill_const(input int r, input int g, input int b);
        for (int i = 0; i < 64; i++) begin
            pr[i] = r;
            pg[i] = g;
            pb[i] = b;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) begin
            pr[i] = $urandom_range(0, 255);
            pg[i] = $urandom_range(0, 255);
            pb[i] = $urandom_range(0, 255);
        end
        blk_x = 16'($urandom) & 16'hFFF8;
        blk_y = 16'($urandom) & 16'hFFF8;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int nblk;
        pix.valid   = 1'b0;
        pix.pixel_x = '0;
        pix.pixel_y = '0;
        pix.pixel_r = '0;
        pix.pixel_g = '0;
        pix.pixel_b = '0;
        blk_x = '0;
        blk_y = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid", 32'(smp.valid), 32'd0);
        check("rst_data", smp.data, 32'd0);
        check("rst_idx", 32'(smp.idx), 32'd0);
        check("rst_id", smp.id, 32'd0);
        check("rst_idle", 32'(idle_o), 32'd1);
        check("rst_in_accept", 32'(pix.accept), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Hand-computed values anchoring the model
        check("model_y_red", 32'(y_of(255, 0, 0)), 32'hFFFF_FFCC);
        check("model_cb_red", 32'(cb_of(255, 0, 0)), 32'hFFFF_FFD4);
        check("model_cr_red", 32'(cr_of(255, 0, 0)), 32'd127);
        check("model_y_white", 32'(y_of(255, 255, 255)), 32'd127);
        check("model_cb_white", 32'(cb_of(255, 255, 255)), 32'd0);
        check("model_cr_white", 32'(cr_of(255, 255, 255)), 32'd0);
        check("model_y_black", 32'(y_of(0, 0, 0)), 32'hFFFF_FF80);

        // Mode 0 black block at pixel (16,8), then end of image
        start_img(2'd0);
        fill_const(0, 0, 0);
        blk_x = 16'd16;
        blk_y = 16'd8;
        push_block(0);
        send_block(64, -1, 1'b1, 32'hFFFF_FF80, 32'h0001_0002);
        push_eof();
        pulse_end();
        wait_idle_drained();

        // Mode 1 pure red
        start_img(2'd1);
        fill_const(255, 0, 0);
        blk_x = 16'd0;
        blk_y = 16'd0;
        push_block(1);
        send_block(64, -1, 1'b1, 32'hFFFF_FFCC, 32'h0000_0000);
        push_eof();
        pulse_end();
        wait_idle_drained();

        // Mode 1 white at pixel (8,24)
        start_img(2'd1);
        fill_const(255, 255, 255);
        blk_x = 16'd8;
        blk_y = 16'd24;
        push_block(1);
        send_block(64, -1, 1'b1, 32'd127, 32'h0003_0001);
        push_eof();
        pulse_end();
        wait_idle_drained();

        // Random images with output stalls; end arrives mid-way through the last block
        stall_en = 1'b1;
        for (int m = 0; m < 2; m++) begin
            start_img(2'(m));
            nblk = 3;
            for (int k = 0; k < nblk; k++) begin
                fill_rand();
                push_block(m);
                if (k == nblk - 1) begin
                    push_eof();
                    send_block(64, 30, 1'b0, 32'd0, 32'd0);
                end else begin
                    send_block(64, -1, 1'b0, 32'd0, 32'd0);
                end
            end
            wait_idle_drained();
        end
        stall_en = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;

        // Unsupported mode: pixels taken, nothing emitted
        start_img(2'd2);
        fill_rand();
        send_block(8, -1, 1'b0, 32'd0, 32'd0);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("mode2_no_output", 32'(smp.valid), 32'd0);
        check("mode2_not_idle", 32'(idle_o), 32'd0);
        @(posedge clk_i);
        #1;
        start_img(2'd0);
        push_eof();
        pulse_end();
        wait_idle_drained();

        // Restart in the middle of a block (Cr replay when chroma is built)
        start_img(2'd1);
        fill_rand();
        push_block(1);
        if (YC) begin
            send_block(64, -1, 1'b0, 32'd0, 32'd0);
            for (int t = 0; t < 1000; t++) begin
                @(negedge clk_i);
                if (smp.valid === 1'b1 && smp.id[31:30] == 2'd2 && smp.idx == 6'd10) break;
            end
        end else begin
            send_block(20, -1, 1'b0, 32'd0, 32'd0);
        end
        flushing = 1'b1;
        @(posedge clk_i);
        #1;
        img_start_i = 1'b1;
        @(posedge clk_i);
        #1;
        img_start_i = 1'b0;
        check("valid_after_start", 32'(smp.valid), 32'd0);
        expq.delete();
        flushing = 1'b0;
        fill_rand();
        push_block(1);
        send_block(64, -1, 1'b1, 32'(y_of(pr[0], pg[0], pb[0])),
                   {2'd0, 14'(blk_y >> 3), blk_x >> 3});
        push_eof();
        pulse_end();
        wait_idle_drained();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
